// File: rtl/memory_pkg.sv
// Shared types and helpers for the parametrised memory slave.
// State encoding, latency limit and byte-lane merge.
package memory_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } mem_state_e;

    localparam int MAX_RD_LATENCY = 8;
    localparam int MAX_DATA_W     = 256;

    // Operands are widened to MAX_DATA_W so one function serves every width
    function automatic logic [MAX_DATA_W-1:0] strb_merge(
        input logic [MAX_DATA_W-1:0]   old_w,
        input logic [MAX_DATA_W-1:0]   new_w,
        input logic [MAX_DATA_W/8-1:0] strb
    );
        logic [MAX_DATA_W-1:0] r_res;
        r_res = old_w;
        for (int i = 0; i < MAX_DATA_W/8; i++) begin
            if (strb[i]) r_res[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return r_res;
    endfunction

endpackage

// File: rtl/memory_if.sv
// Request/response bundle between driver, monitors and memory_slave.
// Parameters mirror the slave so one instance fits any build.
interface memory_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 16,
    parameter int RD_LATENCY = 2
) (
    input logic clk
);
    logic                    reset;
    logic                    req;
    logic                    wr;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    busy;
    logic                    slv_rsp;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;

    modport drv (
        input  clk, busy, slv_rsp, rdata, err,
        output reset, req, wr, addr, wdata, wstrb
    );

    modport slv (
        input  clk, reset, req, wr, addr, wdata, wstrb,
        output busy, slv_rsp, rdata, err
    );

    modport mon (
        input clk, reset, req, wr, addr, wdata, wstrb,
        input busy, slv_rsp, rdata, err
    );

endinterface

// File: rtl/memory_bank.sv
// Flop storage array with async clear, byte-strobed write port
// and combinational read port.
module memory_bank
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 16,
    parameter int IDX_W      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_we,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    output logic [DATA_WIDTH-1:0]   o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];
    logic [MAX_DATA_W-1:0] w_merged;

    assign w_merged = strb_merge(MAX_DATA_W'(r_mem[i_idx]),
                                 MAX_DATA_W'(i_wdata),
                                 (MAX_DATA_W/8)'(i_wstrb));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_SIZE; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_idx] <= DATA_WIDTH'(w_merged);
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/memory_slave.sv
// Memory slave: request/busy handshake, configurable read latency,
// one-cycle completion pulse and out-of-range error reporting.
module memory_slave
    import memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    wr,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    busy,
    output logic                    slv_rsp,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    err
);
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int CNT_W = $clog2(MAX_RD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (RD_LATENCY > 1) ? CNT_W'(RD_LATENCY - 2) : '0;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > MAX_DATA_W) begin : g_bad_dw
        $error("memory_slave: DATA_WIDTH must be a multiple of 8");
    end
    if (MEM_SIZE < 1 || MEM_SIZE > 2**ADDR_WIDTH) begin : g_bad_size
        $error("memory_slave: MEM_SIZE out of range");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_lat
        $error("memory_slave: RD_LATENCY out of range");
    end

    mem_state_e            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_snap;
    logic                  r_snap_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic                  w_in_range;
    logic                  w_we;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_bank_rdata;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_in_range = 32'(addr) < 32'(MEM_SIZE);
    assign w_idx      = addr[IDX_W-1:0];
    assign w_we       = (r_state == IDLE) && req && wr && w_in_range;
    assign w_rd_word  = w_in_range ? w_bank_rdata : '0;

    memory_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (MEM_SIZE),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wdata (wdata),
        .i_wstrb (wstrb),
        .o_rdata (w_bank_rdata)
    );

    // rdata/err change only on the edge that enters RESP, so they hold
    // between responses and a write response leaves rdata untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_snap     <= '0;
            r_snap_err <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req && wr) begin
                        r_err   <= !w_in_range;
                        r_state <= RESP;
                    end else if (req && RD_LATENCY == 1) begin
                        r_rdata <= w_rd_word;
                        r_err   <= !w_in_range;
                        r_state <= RESP;
                    end else if (req) begin
                        r_snap     <= w_rd_word;
                        r_snap_err <= !w_in_range;
                        r_cnt      <= CNT_LOAD;
                        r_state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rdata <= r_snap;
                        r_err   <= r_snap_err;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state != IDLE);
    assign slv_rsp = (r_state == RESP);
    assign rdata   = r_rdata;
    assign err     = r_err;

endmodule

// File: tb/tb_memory_slave.sv
// Directed bench for memory_slave: reset contents, strobes, range
// errors, busy hold-off, latency builds 1/2/8 and mid-read reset.
module tb_memory_slave;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    memory_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) mif (.clk(clk));

    memory_slave u_dut (
        .clk     (clk),
        .reset   (rst),
        .req     (mif.req),
        .wr      (mif.wr),
        .addr    (mif.addr),
        .wdata   (mif.wdata),
        .wstrb   (mif.wstrb),
        .busy    (mif.busy),
        .slv_rsp (mif.slv_rsp),
        .rdata   (mif.rdata),
        .err     (mif.err)
    );

    logic        l1_busy, l1_rsp, l1_err;
    logic [31:0] l1_rdata;
    logic        l8_busy, l8_rsp, l8_err;
    logic [31:0] l8_rdata;

    memory_slave #(.RD_LATENCY(1)) u_lat1 (
        .clk     (clk),
        .reset   (rst),
        .req     (mif.req),
        .wr      (mif.wr),
        .addr    (mif.addr),
        .wdata   (mif.wdata),
        .wstrb   (mif.wstrb),
        .busy    (l1_busy),
        .slv_rsp (l1_rsp),
        .rdata   (l1_rdata),
        .err     (l1_err)
    );

    memory_slave #(.RD_LATENCY(8)) u_lat8 (
        .clk     (clk),
        .reset   (rst),
        .req     (mif.req),
        .wr      (mif.wr),
        .addr    (mif.addr),
        .wdata   (mif.wdata),
        .wstrb   (mif.wstrb),
        .busy    (l8_busy),
        .slv_rsp (l8_rsp),
        .rdata   (l8_rdata),
        .err     (l8_err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse monitor samples on posedge, i.e. the value of the cycle just ended
    int   pulses = 0;
    int   b2b    = 0;
    logic prev_rsp = 1'b0;
    always @(posedge clk) begin
        if (mif.slv_rsp) pulses++;
        if (mif.slv_rsp && prev_rsp) b2b++;
        prev_rsp = mif.slv_rsp;
    end

    task automatic txn(input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output int lat, output logic [31:0] rd,
                       output logic e);
        int g;
        g = 0;
        @(negedge clk);
        while (mif.busy && g < 20) begin
            @(negedge clk);
            g++;
        end
        mif.req   = 1'b1;
        mif.wr    = w;
        mif.addr  = a;
        mif.wdata = d;
        mif.wstrb = s;
        @(posedge clk);
        #1;
        mif.req = 1'b0;
        lat = 1;
        while (!mif.slv_rsp && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = mif.rdata;
        e  = mif.err;
    endtask

    int          lat, k, k1, k2, km, kl1, kl8, p0, b0;
    logic [31:0] rd, d1, d2, dm, dl1, dl8;
    logic        e, seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        mif.reset = 1'b0;
        mif.req   = 1'b0;
        mif.wr    = 1'b0;
        mif.addr  = '0;
        mif.wdata = '0;
        mif.wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(mif.busy), 32'd0);
        chk("rst_rsp", 32'(mif.slv_rsp), 32'd0);
        chk("rst_rdata", mif.rdata, 32'd0);
        chk("rst_err", 32'(mif.err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            txn(1'b0, 8'(i), 32'd0, 4'd0, lat, rd, e);
            chk($sformatf("t1_lat%0d", i), 32'(lat), 32'd2);
            chk($sformatf("t1_rd%0d", i), rd, 32'd0);
            chk($sformatf("t1_err%0d", i), 32'(e), 32'd0);
        end

        txn(1'b1, 8'd3, 32'hDEADBEEF, 4'b1111, lat, rd, e);
        chk("t2_w1_lat", 32'(lat), 32'd1);
        chk("t2_w1_err", 32'(e), 32'd0);
        txn(1'b1, 8'd3, 32'h11223344, 4'b0101, lat, rd, e);
        chk("t2_w2_lat", 32'(lat), 32'd1);
        txn(1'b0, 8'd3, 32'd0, 4'd0, lat, rd, e);
        chk("t2_rd_lat", 32'(lat), 32'd2);
        chk("t2_rd", rd, 32'hDE22BE44);
        chk("t2_err", 32'(e), 32'd0);

        txn(1'b1, 8'd16, 32'hA5A5A5A5, 4'b1111, lat, rd, e);
        chk("t3_w_lat", 32'(lat), 32'd1);
        chk("t3_w_err", 32'(e), 32'd1);
        chk("t3_w_hold", rd, 32'hDE22BE44);
        txn(1'b0, 8'd16, 32'd0, 4'd0, lat, rd, e);
        chk("t3_r16", rd, 32'd0);
        chk("t3_r16_err", 32'(e), 32'd1);
        txn(1'b0, 8'd0, 32'd0, 4'd0, lat, rd, e);
        chk("t3_r0", rd, 32'd0);
        chk("t3_r0_err", 32'(e), 32'd0);

        txn(1'b1, 8'd5, 32'h55555555, 4'b1111, lat, rd, e);
        @(negedge clk);
        while (mif.busy) @(negedge clk);
        p0 = pulses;
        b0 = b2b;
        mif.req  = 1'b1;
        mif.wr   = 1'b0;
        mif.addr = 8'd4;
        @(posedge clk);
        #1;
        mif.addr = 8'd5;
        k = 1; k1 = 0; k2 = 0; d1 = '0; d2 = '0; seen = 1'b0;
        while (k2 == 0 && k < 30) begin
            if (mif.req && mif.busy && seen) mif.req = 1'b0;
            if (mif.slv_rsp && !seen) begin
                k1 = k; d1 = mif.rdata; seen = 1'b1;
            end else if (mif.slv_rsp && seen) begin
                k2 = k; d2 = mif.rdata;
            end
            if (k2 == 0) begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        mif.req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_k1", 32'(k1), 32'd2);
        chk("t4_d1", d1, 32'd0);
        chk("t4_k2", 32'(k2), 32'd5);
        chk("t4_d2", d2, 32'h55555555);
        chk("t4_pulses", 32'(pulses - p0), 32'd2);
        chk("t4_b2b", 32'(b2b - b0), 32'd0);

        txn(1'b1, 8'd2, 32'h12345678, 4'b1111, lat, rd, e);
        txn(1'b1, 8'd16, 32'hFFFFFFFF, 4'b1111, lat, rd, e);
        chk("t6_pre_err", 32'(e), 32'd1);
        chk("t6_pre_rd", rd, 32'h55555555);
        @(negedge clk);
        while (mif.busy) @(negedge clk);
        mif.req  = 1'b1;
        mif.wr   = 1'b0;
        mif.addr = 8'd2;
        @(posedge clk);
        #1;
        mif.req = 1'b0;
        chk("t6_rdwait_busy", 32'(mif.busy), 32'd1);
        p0 = pulses;
        rst = 1'b1;
        #1;
        chk("t6_busy", 32'(mif.busy), 32'd0);
        chk("t6_rdata", mif.rdata, 32'd0);
        chk("t6_err", 32'(mif.err), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_rsp", 32'(pulses - p0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 8'd2, 32'd0, 4'd0, lat, rd, e);
        chk("t6_after_lat", 32'(lat), 32'd2);
        chk("t6_after_rd", rd, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("t5_l1_busy", 32'(l1_busy), 32'd0);
        chk("t5_l8_busy", 32'(l8_busy), 32'd0);
        mif.req   = 1'b1;
        mif.wr    = 1'b1;
        mif.addr  = 8'd7;
        mif.wdata = 32'h0BADF00D;
        mif.wstrb = 4'b1111;
        @(posedge clk);
        #1;
        mif.req = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        mif.req = 1'b1;
        mif.wr  = 1'b0;
        @(posedge clk);
        #1;
        mif.req = 1'b0;
        km = 0; kl1 = 0; kl8 = 0;
        dm = '0; dl1 = '0; dl8 = '0;
        for (int j = 1; j <= 12; j++) begin
            if (mif.slv_rsp && km == 0) begin km = j; dm = mif.rdata; end
            if (l1_rsp && kl1 == 0) begin kl1 = j; dl1 = l1_rdata; end
            if (l8_rsp && kl8 == 0) begin kl8 = j; dl8 = l8_rdata; end
            @(posedge clk);
            #1;
        end
        chk("t5_l2_k", 32'(km), 32'd2);
        chk("t5_l2_d", dm, 32'h0BADF00D);
        chk("t5_l1_k", 32'(kl1), 32'd1);
        chk("t5_l1_d", dl1, 32'h0BADF00D);
        chk("t5_l1_err", 32'(l1_err), 32'd0);
        chk("t5_l8_k", 32'(kl8), 32'd8);
        chk("t5_l8_d", dl8, 32'h0BADF00D);
        chk("t5_l8_err", 32'(l8_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
